// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor.
// Latency: n/a (package only).
// Backpressure: n/a.
package serial_subtractor_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

    // Sequencer state encoding. It matches the bit-serial adder so both
    // datapaths can share debug and display tooling.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/serial_subtractor_shift.sv
// WIDTH-bit right-shift register with sync clear, parallel load and serial-in MSB.
// Latency: 1 cycle from any control to q_o; lsb_o is simply bit 0 of the register.
// Backpressure: none; the register acts on every clock where a control is asserted.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clr_i         clear to 0 (priority over load and shift)
//   load_i        parallel load from load_dat_i
//   shift_i       shift right, sin_i enters at bit WIDTH-1
//   q_o, lsb_o    register contents and its bit 0
module sub_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             sin_i,
    input  logic [WIDTH-1:0] load_dat_i,
    output logic [WIDTH-1:0] q_o,
    output logic             lsb_o
);

    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_d;

    always_comb begin
        reg_d = reg_q;
        if (clr_i) begin
            reg_d = '0;
        end else if (load_i) begin
            reg_d = load_dat_i;
        end else if (shift_i) begin
            reg_d = {sin_i, reg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign q_o   = reg_q;
    assign lsb_o = reg_q[0];

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = A - B mod 2^WIDTH, LSB first.
// Latency: go edge to done pulse is WIDTH+2 cycles; one op per WIDTH+3 cycles back-to-back.
// Backpressure: none; go is only honoured in IDLE and is dropped (not queued) while busy.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   go            start request, sampled in IDLE
//   A, B          minuend and subtrahend, captured in the LOAD cycle
//   diff, borrow  registered result and final borrow (1 when A < B unsigned)
//   busy          high during LOAD and SHIFT
//   done          one-cycle pulse in the cycle diff/borrow take a new value
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;

    logic             in_load;
    logic             in_shift;
    logic             last_bit;
    logic             a_bit, b_bit;
    logic             d_bit, br_n;
    logic [WIDTH-1:0] ra_q, rb_q, res_q;

    assign in_load  = (state_q == S_LOAD);
    assign in_shift = (state_q == S_SHIFT);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // One full-subtractor slice: borrow out when b exceeds a, or they
    // are equal and a borrow is already pending.
    assign d_bit = a_bit ^ b_bit ^ br_q;
    assign br_n  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

    sub_shift_reg #(.WIDTH(WIDTH)) u_ra (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (1'b0),
        .load_i     (in_load),
        .shift_i    (in_shift),
        .sin_i      (1'b0),
        .load_dat_i (A),
        .q_o        (ra_q),
        .lsb_o      (a_bit)
    );

    sub_shift_reg #(.WIDTH(WIDTH)) u_rb (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (1'b0),
        .load_i     (in_load),
        .shift_i    (in_shift),
        .sin_i      (1'b0),
        .load_dat_i (B),
        .q_o        (rb_q),
        .lsb_o      (b_bit)
    );

    // Result bits enter at the MSB; after WIDTH shifts bit 0 of the
    // difference has arrived at bit 0.
    sub_shift_reg #(.WIDTH(WIDTH)) u_res (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (in_load),
        .load_i     (1'b0),
        .shift_i    (in_shift),
        .sin_i      (d_bit),
        .load_dat_i ('0),
        .q_o        (res_q),
        .lsb_o      ()
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                br_d    = 1'b0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                br_d  = br_n;
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                diff_d   = res_q;
                borrow_d = br_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign done   = done_q;
    assign busy   = in_load | in_shift;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor with directed and random operands.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       go;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] diff;
    logic       borrow;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8), .CNT_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .A      (A),
        .B      (B),
        .diff   (diff),
        .borrow (borrow),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [7:0] ref_diff(input logic [7:0] a, input logic [7:0] b);
        int r;
        r = (int'(a) - int'(b) + 256) % 256;
        return 8'(r);
    endfunction

    function automatic logic ref_borrow(input logic [7:0] a, input logic [7:0] b);
        return int'(a) < int'(b);
    endfunction

    // Starts one operation and watches 30 cycles after the go edge.
    // inj > 0 pulses go (with zeroed operands) after edge inj; it must be ignored.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int inj);
        int lat;
        int bcnt;
        int dcnt;
        lat  = 0;
        bcnt = 0;
        dcnt = 0;
        @(negedge clk);
        A  = a;
        B  = b;
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        if (busy) bcnt++;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat == 0) begin
                    lat = n;
                    chk("diff", 32'(diff), 32'(ref_diff(a, b)));
                    chk("borrow", 32'(borrow), 32'(ref_borrow(a, b)));
                end
            end
            if (inj != 0 && n == inj) begin
                A  = 8'd0;
                B  = 8'd0;
                go = 1'b1;
            end else if (inj != 0 && n == inj + 1) begin
                go = 1'b0;
            end
        end
        chk("latency", 32'(lat), 32'd10);
        chk("busy_cycles", 32'(bcnt), 32'd9);
        chk("done_pulses", 32'(dcnt), 32'd1);
    endtask

    initial begin
        int dcnt;
        int last_t;
        logic [7:0] ra, rb;

        rst = 1'b1;
        go  = 1'b0;
        A   = 8'd0;
        B   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Directed operands, including equal, zero and wrap-around cases.
        run_op(8'd200, 8'd55, 0);
        run_op(8'd5, 8'd10, 0);
        run_op(8'hFF, 8'hFF, 0);
        run_op(8'd0, 8'd1, 0);
        run_op(8'd0, 8'd0, 0);
        run_op(8'd100, 8'd1, 4);

        // Reset in the middle of SHIFT aborts and clears the held result.
        @(negedge clk);
        A  = 8'd50;
        B  = 8'd20;
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_borrow", 32'(borrow), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        rst  = 1'b0;
        dcnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) dcnt++;
        end
        chk("abort_quiet", 32'(dcnt), 32'd0);
        run_op(8'd9, 8'd3, 0);

        // go held high: restarts every WIDTH+3 cycles.
        @(negedge clk);
        A      = 8'd7;
        B      = 8'd2;
        go     = 1'b1;
        dcnt   = 0;
        last_t = -1;
        @(posedge clk);
        for (int n = 1; n <= 36; n++) begin
            @(posedge clk);
            #1;
            if (n == 30) go = 1'b0;
            if (done) begin
                dcnt++;
                chk("held_diff", 32'(diff), 32'd5);
                chk("held_borrow", 32'(borrow), 32'd0);
                if (last_t < 0) chk("held_first", 32'(n), 32'd10);
                else chk("held_period", 32'(n - last_t), 32'd11);
                last_t = n;
            end
        end
        chk("held_pulses", 32'(dcnt), 32'd3);

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i % 8 == 0) rb = ra;
            run_op(ra, rb, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing A − B, LSB first, one bit per clock.
- Uses a single borrow flip-flop; the result is shifted into a parallel difference register.
- Companion to the bit-serial adder datapath. Shares its operand-load / shift / count / done control style.
- Feeds the same 7-segment display path; the display wrapper lives outside this block.

Parameters:
WIDTH, 8, operand and difference width in bits.
CNT_W, 4, counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
go  input  1  start request, active-high, sampled in IDLE only
A  input  WIDTH  minuend, captured in LOAD
B  input  WIDTH  subtrahend, captured in LOAD
diff  output  WIDTH  registered difference A−B mod 2^WIDTH
borrow  output  1  registered final borrow (1 when A<B unsigned)
busy  output  1  high in LOAD and SHIFT
done  output  1  one-cycle pulse when diff/borrow update

Behaviour:
- Reset values:
  - With rst=1 at a clock edge: state=IDLE, diff=0, borrow=0, busy=0, done=0.
  - Operand shift registers, partial-result register, borrow FF and counter are all cleared to 0.
  - rst overrides go and any in-flight operation.
- State machine: IDLE, LOAD, SHIFT, FIN, as shared constants.
  - IDLE → LOAD when go=1. Otherwise stay in IDLE.
  - LOAD (1 cycle): capture A into ra and B into rb; clear borrow FF, partial result and counter. → SHIFT.
  - SHIFT (exactly WIDTH cycles):
    - Combinational, with a=ra[0], b=rb[0], br=borrow FF:
      - d = a^b^br
      - br_n = (~a&b) | (~(a^b)&br)
    - Registered each cycle:
      - ra, rb shift right, zero-fill.
      - Partial result shifts right with d inserted at bit WIDTH−1.
      - borrow FF ← br_n.
      - counter += 1.
    - When counter==WIDTH−1 on the current cycle → FIN.
  - FIN (1 cycle): diff ← partial result, borrow ← borrow FF, done=1. → IDLE.
- Latency: go sampled at edge 0; done is high during the cycle after edge WIDTH+2 (10 cycles for WIDTH=8). busy is high for WIDTH+1 cycles.
- Output holding: diff and borrow change only in FIN and hold until the next FIN or a reset.
- go handling: go is ignored in LOAD, SHIFT and FIN; no queuing. go held high continuously restarts on the first IDLE cycle after FIN. Back-to-back throughput is WIDTH+3 cycles per operation.
- A and B may change freely except in the LOAD cycle.
- Width rule: result is modulo 2^WIDTH. borrow equals the carry-out complement of A+~B+1.
- Reset mid-SHIFT: abort immediately. Previous diff/borrow are cleared to 0 and no done pulse is issued.
- Edge operands:
  - A==B gives diff=0, borrow=0.
  - A=0, B=0 gives 0, 0.
  - The counter never wraps because it is cleared in LOAD.

Decomposition:
- Shared package holds:
  - State encodings: S_IDLE=2'd0, S_LOAD=2'd1, S_SHIFT=2'd2, S_FIN=2'd3.
  - Default WIDTH/CNT_W constants.
- One sub-module: sub_shift_reg. It is a WIDTH-bit register with sync clear, parallel load and right shift with a serial-in MSB, and exposes bit 0.
  - Instantiated 3 times: ra, rb (serial-in tied 0) and the result (serial-in = d).
- Borrow FF, counter and FSM stay in the top level.

Test Plan:
- A=200, B=55, go pulse → done pulse 10 cycles after go edge; diff=145 (8'h91), borrow=0; busy high 9 cycles.
- A=5, B=10 → diff=8'hFB, borrow=1.
- A=8'hFF, B=8'hFF → diff=0, borrow=0. A=0, B=1 → diff=8'hFF, borrow=1.
- Start A=100, B=1; pulse go again at cycle 4 with A=0, B=0 → go ignored, result 99, borrow=0, single done pulse.
- Start A=50, B=20; assert rst at cycle 5 → next cycle diff=0, borrow=0, busy=0, no done. Then go with A=9, B=3 → diff=6, borrow=0.
- go held high for 30 cycles, A=7, B=2 → done pulses every 11 cycles, each with diff=5, borrow=0.
